regfile_onehot_wr: RTL

//  Register bank that sits directly downstream of demux8. It consumes the one-hot

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_onehot_wr_onehot_chk.sv | 28 ++
 rtl/regfile_onehot_wr.sv | 95 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the one-hot-write register bank.
// Holds the default bank geometry and the saturating write-counter limits.
package regfile_pkg;

    localparam int NREG_DEF = 8;
    localparam int DW_DEF   = 32;
    localparam int CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic popcount_gt1(input logic [255:0] v);
        return |(v & (v - 256'd1));
    endfunction

endpackage

// File: rtl/regfile_onehot_wr_onehot_chk.sv
// Classifies a write-enable vector as one-hot or multi-hot.
// Also converts a one-hot vector to its binary register index.
module onehot_chk
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic [NREG-1:0] we_oh,
    output logic            is_onehot,
    output logic            is_multi,
    output logic [AW-1:0]   idx
);

    always_comb begin
        is_multi  = popcount_gt1(256'(we_oh));
        is_onehot = (|we_oh) && !is_multi;
    end

    // OR-reduction of set bit positions; only meaningful when is_onehot is high.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NREG; i++) begin
            if (we_oh[i]) idx = idx | AW'(i);
        end
    end

endmodule

// File: rtl/regfile_onehot_wr.sv
// Register bank fed by a one-hot write-enable vector: one-cycle buffered write-back,
// two bypassing async read ports, hardwired r0, multi-hot error flag, write counter.
module regfile_onehot_wr
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREG-1:0]  we_oh,
    input  logic [DW-1:0]    wdata,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [DW-1:0]    rd1,
    output logic [DW-1:0]    rd2,
    output logic             multi_we_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] wr_cnt
);

    logic [NREG-1:0]  pend_we_q;
    logic [DW-1:0]    pend_data_q;
    logic [DW-1:0]    regs_q [NREG];
    logic             err_q;
    logic [CNT_W-1:0] wr_cnt_q;

    logic             is_onehot;
    logic             is_multi;
    logic [AW-1:0]    wr_idx;

    onehot_chk #(.NREG(NREG)) u_chk (
        .we_oh     (we_oh),
        .is_onehot (is_onehot),
        .is_multi  (is_multi),
        .idx       (wr_idx)
    );

    // Writes aimed at r0 are dropped here so they never reach commit or the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_we_q   <= '0;
            pend_data_q <= '0;
        end else if (is_onehot && (wr_idx != '0)) begin
            pend_we_q   <= we_oh;
            pend_data_q <= wdata;
        end else begin
            pend_we_q   <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (pend_we_q[i]) regs_q[i] <= pend_data_q;
            end
        end
    end

    // A new multi-hot on the clearing edge keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (is_multi) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else if ((|pend_we_q) && (wr_cnt_q != CNT_MAX)) begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        rd1 = '0;
        if (ra1 != '0) rd1 = pend_we_q[ra1] ? pend_data_q : regs_q[ra1];
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) rd2 = pend_we_q[ra2] ? pend_data_q : regs_q[ra2];
    end

    assign multi_we_err = err_q;
    assign wr_cnt       = wr_cnt_q;

endmodule
